// File: rtl/spm_stream_reader.sv
// Streams a contiguous block of scratchpad words out on a valid/ready port.
// Reads are issued on credit so that the fixed-latency return always fits in the output FIFO.
module spm_stream_reader #(
  parameter int URAM_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 64,
  parameter int NB_PIPE         = 3,
  parameter int FIFO_DEPTH      = 8,
  parameter int LEN_WIDTH       = 13
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [URAM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]       i_len,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [URAM_ADDR_WIDTH-1:0] o_spm_addr,
  output logic                       o_spm_en,
  output logic                       o_spm_wr_en,
  output logic [DATA_WIDTH-1:0]      o_spm_wr_data,
  input  logic [DATA_WIDTH-1:0]      i_spm_rd_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       i_ready
);

  // state | meaning
  // IDLE  | waiting for i_start; the first read is issued on the accepting edge
  // ISSUE | one read per cycle while credit allows
  // DRAIN | waiting for returns and the last beat (zero-length bursts pass through here)
  // DONE  | o_done high for this cycle

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = CNT_W + 1;

  generate
    if (NB_PIPE < 1 || FIFO_DEPTH < NB_PIPE + 1) begin : g_param_chk
      $error("spm_stream_reader: FIFO_DEPTH must be >= NB_PIPE+1 and NB_PIPE >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                     state, next_state;
  logic [URAM_ADDR_WIDTH-1:0] addr;
  logic [URAM_ADDR_WIDTH-1:0] spm_addr;
  logic [LEN_WIDTH-1:0]       remaining;
  logic                       spm_en;
  logic                       busy;
  logic                       done;
  logic [NB_PIPE-1:0]         vld_sr;

  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           fifo_cnt;

  logic                       push, pop, fifo_valid;
  logic                       load, issue, drain_ok;
  logic [OUT_W-1:0]           outstanding;
  logic                       credit;

  assign push       = vld_sr[NB_PIPE-1];
  assign fifo_valid = (fifo_cnt != '0);
  assign pop        = fifo_valid & i_ready;

  // The request on the port this cycle is not yet in the shift register but already owns a slot.
  assign outstanding = OUT_W'(fifo_cnt) + OUT_W'($countones(vld_sr)) + OUT_W'(spm_en);
  assign credit      = (outstanding < OUT_W'(FIFO_DEPTH));

  // Completion anticipates a final pop this cycle so o_done follows the last beat directly.
  assign drain_ok = !spm_en && (vld_sr == '0) &&
                    ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && i_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    issue      = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            load       = 1'b1;
            next_state = S_ISSUE;
          end else begin
            next_state = S_DRAIN;
          end
        end
      end
      S_ISSUE: begin
        if (remaining == '0) begin
          next_state = S_DRAIN;
        end else if (credit) begin
          issue = 1'b1;
          if (remaining == LEN_WIDTH'(1)) next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_ok) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spm_en    <= 1'b0;
      spm_addr  <= '0;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_sr    <= '0;
    end else begin
      spm_en <= load | issue;
      if (load) begin
        spm_addr  <= i_base_addr;
        addr      <= i_base_addr + URAM_ADDR_WIDTH'(1);
        remaining <= i_len - LEN_WIDTH'(1);
      end else if (issue) begin
        spm_addr  <= addr;
        addr      <= addr + URAM_ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      done <= (state == S_DRAIN) && drain_ok;
      if ((state == S_IDLE) && i_start)      busy <= 1'b1;
      else if ((state == S_DRAIN) && drain_ok) busy <= 1'b0;
      vld_sr <= (vld_sr << 1) | NB_PIPE'(spm_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_spm_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  assign o_busy        = busy;
  assign o_done        = done;
  assign o_spm_addr    = spm_addr;
  assign o_spm_en      = spm_en;
  assign o_spm_wr_en   = 1'b0;
  assign o_spm_wr_data = '0;
  assign o_valid       = fifo_valid;
  assign o_data        = fifo_valid ? mem[rd_ptr] : '0;

endmodule
